// File: rtl/matrix_scanner_if.sv
// Event bus between the matrix scanner and the downstream decode stage.
// Single-entry valid/ready handshake carrying a key index and press/release flag.
interface matrix_scanner_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] ev_code;
    logic              ev_release;
    logic              ev_valid;
    logic              ev_ready;

    modport master (
        output ev_code,
        output ev_release,
        output ev_valid,
        input  ev_ready
    );

    modport slave (
        input  ev_code,
        input  ev_release,
        input  ev_valid,
        output ev_ready
    );
endinterface

// File: rtl/matrix_scanner.sv
// Row-scanning key matrix controller: one-cold row strobes, synchronized column
// sensing, whole-frame debounce and single-key press/release events.
module matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [ROWS-1:0] row_drv,
    input  logic [COLS-1:0] col_in,
    output logic            ghost,
    output logic            overflow,
    matrix_scanner_if.master ev
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [COLS-1:0] r_sync1, r_sync2;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_div;
    logic [ROWS-1:0] r_row_drv;
    logic [N-1:0]    r_cur, r_raw, r_deb;
    logic [3:0]      r_cnt;
    logic            r_upd;
    logic            r_gen, r_gen_rel;
    logic [CW-1:0]   r_gen_code;
    logic            r_ev_valid, r_ev_rel;
    logic [CW-1:0]   r_ev_code;
    logic            r_ghost, r_ovf;

    logic            w_sample, w_eof, w_eq, w_load;
    logic [RW-1:0]   w_row_nx;
    logic [N-1:0]    w_frame;
    logic [3:0]      w_cnt_nx;
    logic [1:0]      w_old_n, w_new_n;
    logic [CW-1:0]   w_old_k, w_new_k, w_gen_code;
    logic            w_gen, w_gen_rel;

    // Key count saturating at 2: only 0, 1 and "many" matter.
    function automatic logic [1:0] f_cnt(input logic [N-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (v[i] && n != 2'd2) n = n + 2'd1;
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] f_idx(input logic [N-1:0] v);
        logic [CW-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) k = CW'(i);
        end
        return k;
    endfunction

    assign w_sample = (r_div == DW'(SCAN_DIV - 1));
    assign w_eof    = w_sample && (r_row == RW'(ROWS - 1));
    assign w_row_nx = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);

    always_comb begin
        w_frame = r_cur;
        w_frame[r_row*COLS +: COLS] = ~r_sync2;
    end

    assign w_eq     = (w_frame == r_raw);
    assign w_cnt_nx = !w_eq ? 4'd0 :
                      (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;

    always_comb begin
        w_old_n    = f_cnt(r_deb);
        w_new_n    = f_cnt(r_raw);
        w_old_k    = f_idx(r_deb);
        w_new_k    = f_idx(r_raw);
        w_gen      = 1'b0;
        w_gen_rel  = 1'b0;
        w_gen_code = '0;
        if (w_old_n == 2'd0 && w_new_n == 2'd1) begin
            w_gen      = 1'b1;
            w_gen_code = w_new_k;
        end else if (w_old_n == 2'd1 &&
                     (w_new_n == 2'd0 ||
                      (w_new_n == 2'd1 && w_new_k != w_old_k))) begin
            // A direct key swap reports only the release of the old key.
            w_gen      = 1'b1;
            w_gen_rel  = 1'b1;
            w_gen_code = w_old_k;
        end
    end

    assign w_load = r_gen && (!r_ev_valid || ev.ev_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_row     <= '0;
            r_div     <= '0;
            r_row_drv <= ~ROWS'(1);
            r_cur     <= '0;
            r_raw     <= '0;
            r_cnt     <= '0;
            r_upd     <= 1'b0;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
            r_upd   <= 1'b0;
            if (w_sample) begin
                r_div     <= '0;
                r_row     <= w_row_nx;
                r_row_drv <= ~(ROWS'(1) << w_row_nx);
                r_cur     <= w_frame;
                if (w_eof) begin
                    r_raw <= w_frame;
                    r_cnt <= w_cnt_nx;
                    r_upd <= (DEBOUNCE == 1) ||
                             (w_eq && w_cnt_nx >= 4'(DEBOUNCE - 1));
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb      <= '0;
            r_ghost    <= 1'b0;
            r_gen      <= 1'b0;
            r_gen_rel  <= 1'b0;
            r_gen_code <= '0;
        end else begin
            r_gen <= 1'b0;
            if (r_upd) begin
                r_deb      <= r_raw;
                r_ghost    <= (w_new_n == 2'd2);
                r_gen      <= w_gen;
                r_gen_rel  <= w_gen_rel;
                r_gen_code <= w_gen_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_valid <= 1'b0;
            r_ev_rel   <= 1'b0;
            r_ev_code  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load) begin
                r_ev_valid <= 1'b1;
                r_ev_rel   <= r_gen_rel;
                r_ev_code  <= r_gen_code;
            end else if (r_ev_valid && ev.ev_ready) begin
                r_ev_valid <= 1'b0;
            end
            if (r_gen && !w_load) r_ovf <= 1'b1;
        end
    end

    assign row_drv       = r_row_drv;
    assign ghost         = r_ghost;
    assign overflow      = r_ovf;
    assign ev.ev_code    = r_ev_code;
    assign ev.ev_release = r_ev_rel;
    assign ev.ev_valid   = r_ev_valid;
endmodule
